seq_chunk_adder: RTL and testbench

Parametrised multi-cycle adder/subtractor that computes a WIDTH-bit sum CHUNK bits per clock, carrying between chunks in a register. It replaces the fixed 20-bit ripple adder wherever a wide add has to leave the single-cycle timing path. It also adds carry-in, subtraction, carry-out and signed-overflow reporting. It sits between the datapath operand registers and the result bus, and uses a start/busy/done handshake.

---
 rtl/seq_chunk_adder_pkg.sv | 27 ++
 rtl/seq_chunk_adder_chunk_adder.sv | 36 +++
 rtl/seq_chunk_adder.sv | 132 +++++++++++++
 tb/tb_seq_chunk_adder.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/seq_chunk_adder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seq_chunk_adder_pkg
// Brief    : Shared types and elaboration helpers for the chunked adder.
// Revision : 1.0 - initial release
// ============================================================================
package seq_chunk_adder_pkg;

    // Operation sequencer states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Number of CHUNK-bit slices needed to cover WIDTH bits
    function automatic int calc_nchunk(input int width, input int chunk);
        return width / chunk;
    endfunction

    // Width of the chunk index register; never narrower than one bit
    function automatic int calc_idx_w(input int nchunk);
        return (nchunk <= 1) ? 1 : $clog2(nchunk);
    endfunction

endpackage : seq_chunk_adder_pkg
`default_nettype wire

// File: rtl/seq_chunk_adder_chunk_adder.sv
`default_nettype none
// ============================================================================
// Module   : chunk_adder
// Brief    : Combinational CHUNK-bit ripple full adder. Also exposes the carry
//            into its MSB so the caller can derive signed overflow.
// Revision : 1.0 - initial release
// ============================================================================
module chunk_adder #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] i_a,
    input  logic [CHUNK-1:0] i_b,
    input  logic             i_cin,
    output logic [CHUNK-1:0] o_sum,
    output logic             o_cout,
    output logic             o_c_msb
);

    logic [CHUNK:0] w_c;

    // Bit-serial ripple; w_c[i] is the carry into bit i
    always_comb begin
        w_c    = '0;
        o_sum  = '0;
        w_c[0] = i_cin;
        for (int i = 0; i < CHUNK; i++) begin
            o_sum[i]  = i_a[i] ^ i_b[i] ^ w_c[i];
            w_c[i+1]  = (i_a[i] & i_b[i]) | (i_a[i] & w_c[i]) | (i_b[i] & w_c[i]);
        end
    end

    assign o_cout  = w_c[CHUNK];
    assign o_c_msb = w_c[CHUNK-1];

endmodule : chunk_adder
`default_nettype wire

// File: rtl/seq_chunk_adder.sv
`default_nettype none
// ============================================================================
// Module   : seq_chunk_adder
// Brief    : Multi-cycle WIDTH-bit adder/subtractor processing CHUNK bits per
//            clock, with carry-in, carry-out and signed overflow reporting.
//            start/busy/done handshake.
// Revision : 1.0 - initial release
// ============================================================================
module seq_chunk_adder
    import seq_chunk_adder_pkg::*;
#(
    parameter int WIDTH = 20,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);

    localparam int c_NCHUNK = calc_nchunk(WIDTH, CHUNK);
    localparam int c_IDX_W  = calc_idx_w(c_NCHUNK);
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(c_NCHUNK - 1);

    // Reject geometries that cannot be tiled by whole chunks
    generate
        if ((CHUNK < 1) || (CHUNK > WIDTH) || ((WIDTH % CHUNK) != 0)) begin : g_bad_geometry
            $error("seq_chunk_adder: WIDTH must be a positive multiple of CHUNK");
        end
    endgenerate

    state_t             r_state;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic               r_carry;
    logic [c_IDX_W-1:0] r_idx;
    logic [WIDTH-1:0]   r_s;
    logic               r_cout;
    logic               r_ovf;
    logic               r_busy;
    logic               r_done;

    logic [CHUNK-1:0]   w_a_chunk;
    logic [CHUNK-1:0]   w_b_chunk;
    logic [CHUNK-1:0]   w_sum;
    logic               w_cout;
    logic               w_c_msb;

    assign w_a_chunk = r_a[r_idx*CHUNK +: CHUNK];
    assign w_b_chunk = r_b[r_idx*CHUNK +: CHUNK];

    chunk_adder #(
        .CHUNK (CHUNK)
    ) u_chunk_adder (
        .i_a     (w_a_chunk),
        .i_b     (w_b_chunk),
        .i_cin   (r_carry),
        .o_sum   (w_sum),
        .o_cout  (w_cout),
        .o_c_msb (w_c_msb)
    );

    // Sequencer: latch operands on start, walk chunks LSB-first, then pulse done.
    // Subtraction is folded into the latch: B is inverted and the borrow-in is
    // turned into the +1 of the two's-complement negate (carry = cin ^ sub).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_idx   <= '0;
            r_s     <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_a     <= a;
                        r_b     <= sub ? ~b : b;
                        r_carry <= cin ^ sub;
                        r_idx   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_s[r_idx*CHUNK +: CHUNK] <= w_sum;
                    r_carry                   <= w_cout;
                    if (r_idx == c_LAST_IDX) begin
                        r_cout  <= w_cout;
                        r_ovf   <= w_c_msb ^ w_cout;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign s    = r_s;
    assign cout = r_cout;
    assign ovf  = r_ovf;

endmodule : seq_chunk_adder
`default_nettype wire

// File: tb/tb_seq_chunk_adder.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_chunk_adder
// Brief    : Directed and randomised checks of seq_chunk_adder for a
//            WIDTH=20/CHUNK=4 build and a WIDTH=20/CHUNK=20 build.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_chunk_adder;

    localparam int W = 20;

    logic         clk = 1'b0;
    logic         rst;

    // CHUNK=4 instance
    logic         start, sub, cin;
    logic [W-1:0] a, b;
    logic         busy, done, cout, ovf;
    logic [W-1:0] s;

    // CHUNK=20 instance
    logic         wd_start, wd_sub, wd_cin;
    logic [W-1:0] wd_a, wd_b;
    logic         wd_busy, wd_done, wd_cout, wd_ovf;
    logic [W-1:0] wd_s;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    seq_chunk_adder #(.WIDTH(W), .CHUNK(4)) dut (
        .clk (clk), .rst (rst), .start (start), .sub (sub),
        .a (a), .b (b), .cin (cin),
        .busy (busy), .done (done), .s (s), .cout (cout), .ovf (ovf)
    );

    seq_chunk_adder #(.WIDTH(W), .CHUNK(W)) dut_wide (
        .clk (clk), .rst (rst), .start (wd_start), .sub (wd_sub),
        .a (wd_a), .b (wd_b), .cin (wd_cin),
        .busy (wd_busy), .done (wd_done), .s (wd_s), .cout (wd_cout), .ovf (wd_ovf)
    );

    // Single comparison point for the whole bench
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Golden model: returns {ovf, cout, s[19:0]}
    function automatic logic [21:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                          input logic mcin, input logic msub);
        logic [W-1:0] bb;
        logic [W:0]   t;
        logic         v;
        bb = msub ? ~mb : mb;
        t  = {1'b0, ma} + {1'b0, bb} + {{W{1'b0}}, (msub ? ~mcin : mcin)};
        v  = (ma[W-1] == bb[W-1]) && (t[W-1] != ma[W-1]);
        return {v, t[W], t[W-1:0]};
    endfunction

    // Present an operation for one cycle, then scramble the operand inputs
    task automatic launch(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                          input logic tc, input logic ts);
        start = 1'b1; a = ta; b = tb_v; cin = tc; sub = ts;
        @(negedge clk);
        start = 1'b0; a = ~ta; b = ~tb_v; cin = ~tc; sub = ~ts;
    endtask

    // Called at the negedge after the accepting edge minus 'already' cycles consumed
    task automatic wait_done(input string tag, input int already, input logic [W-1:0] es,
                             input logic ec, input logic eo);
        check({tag, "/busy_after_start"}, {30'd0, busy, done}, 32'd2);
        repeat (4 - already) begin
            @(negedge clk);
            check({tag, "/busy_run"}, {30'd0, busy, done}, 32'd2);
        end
        @(negedge clk);
        check({tag, "/done"}, {30'd0, busy, done}, 32'd1);
        check({tag, "/s"}, {12'd0, s}, {12'd0, es});
        check({tag, "/cout_ovf"}, {30'd0, cout, ovf}, {30'd0, ec, eo});
    endtask

    initial begin
        logic [21:0] exp;
        logic [W-1:0] ra, rb;
        logic rc, rs;
        logic saw_done;

        rst = 1'b1; start = 1'b0; sub = 1'b0; cin = 1'b0; a = '0; b = '0;
        wd_start = 1'b0; wd_sub = 1'b0; wd_cin = 1'b0; wd_a = '0; wd_b = '0;
        repeat (2) @(negedge clk);
        check("reset/flags", {28'd0, busy, done, cout, ovf}, 32'd0);
        check("reset/s", {12'd0, s}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Wrap-around add with carry out
        launch(20'hFFFFF, 20'h00001, 1'b0, 1'b0);
        wait_done("add_wrap", 0, 20'h00000, 1'b1, 1'b0);
        @(negedge clk);
        check("add_wrap/pulse_width", {31'd0, done}, 32'd0);

        // Signed overflow on add
        launch(20'h7FFFF, 20'h00001, 1'b0, 1'b0);
        wait_done("add_ovf", 0, 20'h80000, 1'b0, 1'b1);
        @(negedge clk);

        // Subtraction with borrow, then with borrow-in
        launch(20'h00005, 20'h00007, 1'b0, 1'b1);
        wait_done("sub_neg", 0, 20'hFFFFE, 1'b0, 1'b0);
        @(negedge clk);
        launch(20'h00007, 20'h00005, 1'b1, 1'b1);
        wait_done("sub_bin", 0, 20'h00001, 1'b1, 1'b0);
        @(negedge clk);

        // start during RUN must be ignored
        launch(20'h12345, 20'h11111, 1'b0, 1'b0);
        @(negedge clk);
        start = 1'b1; a = 20'hFFFFF; b = 20'hFFFFF; cin = 1'b1; sub = 1'b0;
        @(negedge clk);
        start = 1'b0;
        wait_done("ign_run", 2, 20'h23456, 1'b0, 1'b0);

        // start held through DONE is ignored there, accepted in the following IDLE cycle
        start = 1'b1; a = 20'h00010; b = 20'h00020; cin = 1'b0; sub = 1'b0;
        @(negedge clk);
        check("b2b/ignored_in_done", {30'd0, busy, done}, 32'd0);
        launch(20'h00010, 20'h00020, 1'b0, 1'b0);
        wait_done("b2b", 0, 20'h00030, 1'b0, 1'b0);
        @(negedge clk);
        check("b2b/pulse_width", {31'd0, done}, 32'd0);

        // Asynchronous reset in the 3rd RUN cycle
        launch(20'hAAAAA, 20'h55555, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_mid/flags", {28'd0, busy, done, cout, ovf}, 32'd0);
        check("rst_mid/s", {12'd0, s}, 32'd0);
        saw_done = 1'b0;
        repeat (6) begin
            @(negedge clk);
            saw_done = saw_done | done | busy;
        end
        rst = 1'b0;
        check("rst_mid/no_done", {31'd0, saw_done}, 32'd0);
        @(negedge clk);
        launch(20'h0F0F0, 20'h01010, 1'b1, 1'b0);
        wait_done("after_rst", 0, 20'h10101, 1'b0, 1'b0);
        @(negedge clk);

        // Random regression, CHUNK=4
        for (int i = 0; i < 16; i++) begin
            ra = W'($urandom); rb = W'($urandom);
            rc = 1'($urandom); rs = 1'($urandom);
            exp = model(ra, rb, rc, rs);
            launch(ra, rb, rc, rs);
            wait_done("rand4", 0, exp[W-1:0], exp[W], exp[W+1]);
            @(negedge clk);
        end

        // CHUNK=WIDTH build: done two edges after start
        wd_start = 1'b1; wd_a = 20'h12345; wd_b = 20'h0ABCD; wd_cin = 1'b0; wd_sub = 1'b0;
        @(negedge clk);
        wd_start = 1'b0; wd_a = '0; wd_b = '0;
        check("wide/busy", {30'd0, wd_busy, wd_done}, 32'd2);
        @(negedge clk);
        check("wide/done", {30'd0, wd_busy, wd_done}, 32'd1);
        check("wide/s", {12'd0, wd_s}, 32'h1CF12);
        check("wide/cout_ovf", {30'd0, wd_cout, wd_ovf}, 32'd0);
        @(negedge clk);
        check("wide/pulse_width", {31'd0, wd_done}, 32'd0);

        // Random regression, CHUNK=20
        for (int i = 0; i < 8; i++) begin
            ra = W'($urandom); rb = W'($urandom);
            rc = 1'($urandom); rs = 1'($urandom);
            exp = model(ra, rb, rc, rs);
            wd_start = 1'b1; wd_a = ra; wd_b = rb; wd_cin = rc; wd_sub = rs;
            @(negedge clk);
            wd_start = 1'b0; wd_a = ~ra; wd_b = ~rb;
            @(negedge clk);
            check("rand20/done", {31'd0, wd_done}, 32'd1);
            check("rand20/s", {12'd0, wd_s}, {12'd0, exp[W-1:0]});
            check("rand20/cout_ovf", {30'd0, wd_cout, wd_ovf}, {30'd0, exp[W], exp[W+1]});
            @(negedge clk);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_seq_chunk_adder
`default_nettype wire
